hamming_enc_8to12: RTL and testbench

//  Single-error-correcting Hamming(12,8) encoder with one registered output stage.

---
 rtl/hamming_enc_8to12_if.sv | 20 ++
 rtl/hamming_enc_8to12.sv | 49 ++++
 tb/tb_hamming_enc_8to12.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/hamming_enc_8to12_if.sv
// Handshake bundle for the Hamming(12,8) encoder: byte stream in, codeword stream out.
// The master side feeds bytes and drains codewords; the slave side is the encoder.
interface hamming_enc_8to12_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  data_in;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] data_out;

    modport master (
        output in_valid, data_in, out_ready,
        input  in_ready, out_valid, data_out
    );

    modport slave (
        input  in_valid, data_in, out_ready,
        output in_ready, out_valid, data_out
    );
endinterface

// File: rtl/hamming_enc_8to12.sv
// Hamming(12,8) SEC encoder with a single registered valid/ready output stage.
// Codeword bit i holds Hamming position i+1; parity sits at positions 1, 2, 4 and 8.
module hamming_enc_8to12 (
    input  logic                  clk,
    input  logic                  rst_n,
    hamming_enc_8to12_if.slave    bus
);

    logic [7:0]  d;
    logic        p1;
    logic        p2;
    logic        p4;
    logic        p8;
    logic [11:0] codeword;

    logic [11:0] data_out_reg;
    logic        out_valid_reg;
    logic        in_xfer;

    assign d = bus.data_in;

    // Each parity bit covers the data positions whose index has that bit set.
    assign p1 = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    assign p2 = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    assign p4 = d[1] ^ d[2] ^ d[3] ^ d[7];
    assign p8 = d[4] ^ d[5] ^ d[6] ^ d[7];

    assign codeword = {d[7], d[6], d[5], d[4], p8, d[3], d[2], d[1], p4, d[0], p2, p1};

    // The stage can refill on the same cycle it drains.
    assign bus.in_ready = !out_valid_reg || bus.out_ready;
    assign in_xfer      = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            data_out_reg  <= 12'h000;
        end else if (in_xfer) begin
            out_valid_reg <= 1'b1;
            data_out_reg  <= codeword;
        end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.data_out  = data_out_reg;

endmodule

// File: tb/tb_hamming_enc_8to12.sv
// Directed checks of the Hamming(12,8) encoder against a position-based reference model.
module tb_hamming_enc_8to12;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    hamming_enc_8to12_if bus ();

    hamming_enc_8to12 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: scatter data into non-power-of-two positions, then even parity per index bit.
    function automatic logic [11:0] ref_enc(input logic [7:0] dat);
        logic [11:0] cw;
        int          k;
        logic        par;
        cw = '0;
        k  = 0;
        for (int pos = 1; pos <= 12; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos-1] = dat[k];
                k++;
            end
        end
        for (int p = 1; p <= 8; p = p * 2) begin
            par = 1'b0;
            for (int pos = 1; pos <= 12; pos++)
                if (((pos & p) != 0) && (pos != p))
                    par = par ^ cw[pos-1];
            cw[p-1] = par;
        end
        return cw;
    endfunction

    function automatic logic [3:0] syndrome(input logic [11:0] cw);
        logic [3:0] s;
        s = 4'd0;
        for (int pos = 1; pos <= 12; pos++)
            if (cw[pos-1])
                s = s ^ 4'(pos);
        return s;
    endfunction

    task automatic chk(input string tag, input logic [11:0] observed, input logic [11:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [11:0] model_cw;
    logic [11:0] flipped;

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.data_in  = 8'h00;
        bus.out_ready = 1'b1;
        tick();
        tick();

        chk("reset_out_valid", 12'(bus.out_valid), 12'h000);
        chk("reset_data_out", bus.data_out, 12'h000);
        chk("reset_in_ready", 12'(bus.in_ready), 12'h001);
        rst_n = 1'b1;

        // Single byte 0x00
        bus.in_valid = 1'b1;
        bus.data_in  = 8'h00;
        tick();
        chk("zero_out_valid", 12'(bus.out_valid), 12'h001);
        chk("zero_data_out", bus.data_out, 12'h000);
        bus.in_valid = 1'b0;
        tick();
        chk("zero_drain_valid", 12'(bus.out_valid), 12'h000);

        // Back-to-back stream with hand-computed codewords
        bus.in_valid = 1'b1;
        bus.data_in  = 8'hAA;
        tick();
        chk("stream_AA", bus.data_out, 12'hA58);
        chk("stream_AA_valid", 12'(bus.out_valid), 12'h001);
        chk("stream_in_ready", 12'(bus.in_ready), 12'h001);
        bus.data_in = 8'hF0;
        tick();
        chk("stream_F0", bus.data_out, 12'hF08);
        bus.data_in = 8'h55;
        tick();
        chk("stream_55", bus.data_out, 12'h52F);
        bus.data_in = 8'hFF;
        tick();
        chk("stream_FF", bus.data_out, 12'hF77);
        chk("stream_FF_valid", 12'(bus.out_valid), 12'h001);
        bus.in_valid = 1'b0;
        tick();
        chk("drain_valid", 12'(bus.out_valid), 12'h000);
        chk("drain_hold", bus.data_out, 12'hF77);

        // Exhaustive bytes, streamed one per clock
        bus.in_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bus.data_in = 8'(i);
            tick();
            chk($sformatf("exh_%02h", i), bus.data_out, ref_enc(8'(i)));
            chk($sformatf("syn_%02h", i), 12'(syndrome(bus.data_out)), 12'h000);
        end
        bus.in_valid = 1'b0;
        tick();

        // Stall: hold A58 while 0x55 waits
        bus.in_valid = 1'b1;
        bus.data_in  = 8'hAA;
        tick();
        chk("stall_load", bus.data_out, 12'hA58);
        bus.out_ready = 1'b0;
        bus.data_in   = 8'h55;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stall_in_ready_%0d", c), 12'(bus.in_ready), 12'h000);
            tick();
            chk($sformatf("stall_data_%0d", c), bus.data_out, 12'hA58);
            chk($sformatf("stall_valid_%0d", c), 12'(bus.out_valid), 12'h001);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("unstall_in_ready", 12'(bus.in_ready), 12'h001);
        tick();
        chk("unstall_55", bus.data_out, 12'h52F);
        chk("unstall_valid", 12'(bus.out_valid), 12'h001);
        bus.in_valid = 1'b0;
        tick();
        chk("unstall_drain", 12'(bus.out_valid), 12'h000);

        // Reset while a codeword is held in a stall
        bus.in_valid = 1'b1;
        bus.data_in  = 8'hFF;
        tick();
        chk("pre_reset_valid", 12'(bus.out_valid), 12'h001);
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("midrst_valid", 12'(bus.out_valid), 12'h000);
        chk("midrst_data", bus.data_out, 12'h000);
        chk("midrst_in_ready", 12'(bus.in_ready), 12'h001);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("post_rst_valid", 12'(bus.out_valid), 12'h000);

        // Model sanity: single-bit flips give syndrome = flipped position
        model_cw = ref_enc(8'hA5);
        for (int p = 1; p <= 12; p++) begin
            flipped = model_cw ^ (12'h001 << (p - 1));
            chk($sformatf("flip_pos_%0d", p), 12'(syndrome(flipped)), 12'(p));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
